// File: rtl/univ_shift_reg_pkg.sv
// Shared encodings for the universal shift register: command opcodes and FSM states.
// Also holds the helper that decides whether an opcode needs the multi-cycle SHIFT phase.
package univ_shift_pkg;

   typedef enum logic [2:0] {
      OP_LOAD = 3'd0,
      OP_ROL  = 3'd1,
      OP_ROR  = 3'd2,
      OP_SHL  = 3'd3,
      OP_SHR  = 3'd4,
      OP_ASR  = 3'd5,
      OP_NOP6 = 3'd6,
      OP_NOP7 = 3'd7
   } op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   function automatic logic is_step_op(input op_e op);
      return (op == OP_ROL) || (op == OP_ROR) || (op == OP_SHL) ||
             (op == OP_SHR) || (op == OP_ASR);
   endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Command/status bundle of the universal shift register: master drives commands, slave reports.
// The clock enable travels with the command signals because it gates the whole datapath.
interface univ_shift_reg_if
   import univ_shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH) + 1
);
   logic             e;
   logic             start;
   op_e              op;
   logic [AMT_W-1:0] amt;
   logic [WIDTH-1:0] data;
   logic             sin;
   logic [WIDTH-1:0] out;
   logic             sout;
   logic             busy;
   logic             done;

   modport master (
      output e, start, op, amt, data, sin,
      input  out, sout, busy, done
   );

   modport slave (
      input  e, start, op, amt, data, sin,
      output out, sout, busy, done
   );
endinterface

// File: rtl/univ_shift_reg_step.sv
// One single-bit step of a rotate/shift op: next register value and the bit that leaves.
// Purely combinational; zero latency.
module shift_step
   import univ_shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] cur,
   input  op_e              op,
   input  logic             sin,
   output logic [WIDTH-1:0] nxt,
   output logic             bit_out
);

   always_comb begin
      nxt     = cur;
      bit_out = 1'b0;
      case (op)
         OP_ROL: begin
            nxt     = {cur[WIDTH-2:0], cur[WIDTH-1]};
            bit_out = cur[WIDTH-1];
         end
         OP_ROR: begin
            nxt     = {cur[0], cur[WIDTH-1:1]};
            bit_out = cur[0];
         end
         OP_SHL: begin
            nxt     = {cur[WIDTH-2:0], sin};
            bit_out = cur[WIDTH-1];
         end
         OP_SHR: begin
            nxt     = {sin, cur[WIDTH-1:1]};
            bit_out = cur[0];
         end
         OP_ASR: begin
            nxt     = {cur[WIDTH-1], cur[WIDTH-1:1]};
            bit_out = cur[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: load in one cycle, or run amt one-bit steps, then pulse done.
// A shift of N steps signals done N+1 cycles after acceptance; e=0 stalls everything one cycle.
module univ_shift_reg
   import univ_shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic           clk,
   input  logic           rst,
   univ_shift_reg_if.slave bus
);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             sout_q, sout_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] step_val;
   logic             step_bit;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .cur     (out_q),
      .op      (op_q),
      .sin     (bus.sin),
      .nxt     (step_val),
      .bit_out (step_bit)
   );

   // done is a strict one-cycle pulse, so it drops even while e=0 holds everything else.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      sout_d  = sout_q;
      done_d  = 1'b0;
      if (bus.e) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  if (bus.op == OP_LOAD) begin
                     out_d  = bus.data;
                     done_d = 1'b1;
                  end else if (is_step_op(bus.op) && (bus.amt != '0)) begin
                     op_d    = bus.op;
                     cnt_d   = bus.amt;
                     state_d = ST_SHIFT;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               out_d  = step_val;
               sout_d = step_bit;
               cnt_d  = cnt_q - AMT_W'(1);
               if (cnt_q == AMT_W'(1)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_LOAD;
         cnt_q   <= '0;
         out_q   <= '0;
         sout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         sout_q  <= sout_d;
         done_q  <= done_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.sout = sout_q;
   assign bus.busy = (state_q == ST_SHIFT);
   assign bus.done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios plus random commands against a closed-form model.
// The model computes whole multi-step results at once (rotate by amt mod WIDTH, bulk shifts with fill).
module tb_univ_shift_reg;
   import univ_shift_pkg::*;

   localparam int W  = 8;
   localparam int AW = $clog2(W) + 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   univ_shift_reg_if #(.WIDTH(W), .AMT_W(AW)) bus ();
   univ_shift_reg #(.WIDTH(W), .AMT_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0] m_val;
   logic         m_sout;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns {sout, value} after n single-bit steps, evaluated in one go.
   function automatic logic [W:0] ref_shift(input logic [W-1:0] v, input op_e op, input int n,
                                            input logic s, input logic so_prev);
      logic [2*W-1:0] t;
      logic [W-1:0]   r;
      logic [W-1:0]   ff;
      logic           b;
      int             k;
      ff = '1;
      r  = v;
      b  = so_prev;
      k  = n % W;
      case (op)
         OP_ROL: begin r = (v << k) | (v >> (W - k)); b = r[0]; end
         OP_ROR: begin r = (v >> k) | (v << (W - k)); b = r[W-1]; end
         OP_SHL: begin
            t = {{W{1'b0}}, v} << n;
            r = t[W-1:0] | (s ? ~(ff << n) : '0);
            b = (n <= W) ? t[W] : s;
         end
         OP_SHR: begin
            t = {v, {W{1'b0}}} >> n;
            r = t[2*W-1:W] | (s ? ~(ff >> n) : '0);
            b = (n <= W) ? t[W-1] : s;
         end
         OP_ASR: begin
            r = $signed(v) >>> n;
            b = (n <= W) ? v[n-1] : v[W-1];
         end
         default: ;
      endcase
      return {b, r};
   endfunction

   task automatic do_reset(input logic e_val);
      rst = 1'b1; bus.e = e_val; bus.start = 1'b0;
      tick();
      rst = 1'b0; bus.e = 1'b1;
      m_val = '0; m_sout = 1'b0;
      check_eq("rst_out",  32'(bus.out),  32'd0);
      check_eq("rst_sout", 32'(bus.sout), 32'd0);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
   endtask

   // Issue one command, stall per mask/percentage, optionally spray start while busy.
   task automatic run_cmd(input op_e op, input int amt, input logic [W-1:0] d, input logic s,
                          input logic [31:0] stall_mask, input int stall_pct, input int junk_pct);
      logic [W:0]   exp;
      logic         is_sh;
      logic         e_v;
      logic [W-1:0] prev;
      logic         prev_so;
      int           cyc;
      int           stalls;
      is_sh = is_step_op(op) && (amt != 0);
      exp   = {m_sout, m_val};
      if (op == OP_LOAD) exp = {m_sout, d};
      else if (is_sh)    exp = ref_shift(m_val, op, amt, s, m_sout);

      bus.e = 1'b1; bus.start = 1'b1; bus.op = op; bus.amt = AW'(amt);
      bus.data = d; bus.sin = s;
      tick();
      bus.start = 1'b0;
      cyc = 1; stalls = 0;
      while (!bus.done && cyc < 200) begin
         check_eq("busy", 32'(bus.busy), 32'd1);
         e_v = 1'b1;
         if (cyc < 32 && stall_mask[cyc]) e_v = 1'b0;
         if (int'($urandom_range(99)) < stall_pct) e_v = 1'b0;
         bus.e = e_v;
         if (!e_v) stalls++;
         if (int'($urandom_range(99)) < junk_pct) begin
            bus.start = 1'b1;
            bus.op    = op_e'(3'($urandom_range(7)));
            bus.amt   = AW'($urandom);
            bus.data  = W'($urandom);
         end
         prev = bus.out; prev_so = bus.sout;
         tick();
         bus.start = 1'b0; bus.e = 1'b1;
         if (!e_v) check_eq("freeze", 32'({prev_so, prev}), 32'({bus.sout, bus.out}));
         cyc++;
      end
      check_eq("done_lat",  32'(cyc), 32'(is_sh ? amt + 1 + stalls : 1));
      check_eq("out",       32'(bus.out),  32'(exp[W-1:0]));
      check_eq("sout",      32'(bus.sout), 32'(exp[W]));
      check_eq("busy_done", 32'(bus.busy), 32'd0);
      tick();
      check_eq("done_once", 32'(bus.done), 32'd0);
      check_eq("out_hold",  32'(bus.out),  32'(exp[W-1:0]));
      m_val = exp[W-1:0]; m_sout = exp[W];
   endtask

   initial begin
      rst = 1'b0; bus.e = 1'b0; bus.start = 1'b0; bus.op = OP_NOP7;
      bus.amt = '0; bus.data = '0; bus.sin = 1'b0;
      m_val = '0; m_sout = 1'b0;

      // reset honoured even with e=0
      do_reset(1'b0);

      run_cmd(OP_LOAD, 0, 8'hA5, 1'b0, 32'h0, 0, 0);
      run_cmd(OP_LOAD, 0, 8'h81, 1'b0, 32'h0, 0, 0);
      run_cmd(OP_ROL,  3, 8'h00, 1'b0, 32'h0, 0, 0);
      check_eq("rol3_val", 32'(bus.out), 32'h0C);

      run_cmd(OP_LOAD, 0, 8'h80, 1'b0, 32'h0, 0, 0);
      run_cmd(OP_ASR,  3, 8'h00, 1'b0, 32'h0, 0, 0);
      check_eq("asr3_val", 32'(bus.out), 32'hF0);
      run_cmd(OP_LOAD, 0, 8'h01, 1'b0, 32'h0, 0, 0);
      run_cmd(OP_SHR,  2, 8'h00, 1'b1, 32'h0, 0, 0);
      check_eq("shr2_val",  32'(bus.out),  32'hC0);
      check_eq("shr2_sout", 32'(bus.sout), 32'h0);

      // rol 4 with two stalled cycles mid-operation: done lands on cycle 7
      run_cmd(OP_LOAD, 0, 8'h3B, 1'b0, 32'h0, 0, 0);
      run_cmd(OP_ROL,  4, 8'h00, 1'b0, 32'h0000_000C, 0, 0);
      check_eq("rol4_val", 32'(bus.out), 32'hB3);

      // amt=0, nop, oversize amt, and start sprayed during busy
      run_cmd(OP_SHL,  0, 8'h00, 1'b1, 32'h0, 0, 0);
      run_cmd(OP_NOP6, 5, 8'hFF, 1'b1, 32'h0, 0, 0);
      run_cmd(OP_ROR, 11, 8'h00, 1'b0, 32'h0, 0, 0);
      run_cmd(OP_SHL,  6, 8'h00, 1'b1, 32'h0, 0, 100);

      // reset during the second step of shl 5 aborts with no done
      run_cmd(OP_LOAD, 0, 8'h5A, 1'b0, 32'h0, 0, 0);
      bus.start = 1'b1; bus.op = OP_SHL; bus.amt = AW'(5); bus.sin = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_val = '0; m_sout = 1'b0;
      check_eq("abort_out",  32'(bus.out),  32'd0);
      check_eq("abort_busy", 32'(bus.busy), 32'd0);
      check_eq("abort_done", 32'(bus.done), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check_eq("abort_nodone", 32'(bus.done), 32'd0);
      end

      // reset beats a simultaneous load
      run_cmd(OP_LOAD, 0, 8'h77, 1'b0, 32'h0, 0, 0);
      rst = 1'b1; bus.start = 1'b1; bus.op = OP_LOAD; bus.data = 8'hEE;
      tick();
      rst = 1'b0; bus.start = 1'b0;
      m_val = '0; m_sout = 1'b0;
      check_eq("rst_prio_out",  32'(bus.out),  32'd0);
      check_eq("rst_prio_done", 32'(bus.done), 32'd0);
      tick();
      check_eq("rst_prio_done2", 32'(bus.done), 32'd0);

      for (int i = 0; i < 80; i++) begin
         run_cmd(op_e'(3'($urandom_range(7))), int'($urandom_range((1 << AW) - 1)),
                 W'($urandom), 1'($urandom), 32'h0, 20, 25);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter: WIDTH, 8, register width in bits (>=2).
REQ-002 Parameter: AMT_W, $clog2(WIDTH)+1, width of the shift-amount port.
REQ-003 Reset: one clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: e  in  1  clock enable; when 0, all state, counter and outputs hold.
REQ-007 Port: start  in  1  command strobe; accepted only in IDLE with e=1.
REQ-008 Port: op  in  3  command: 000 load, 001 rol, 010 ror, 011 shl, 100 shr, 101 asr, 110/111 nop.
REQ-009 Port: amt  in  AMT_W  number of one-bit steps for shift/rotate ops.
REQ-010 Port: data  in  WIDTH  parallel load value, sampled only at load acceptance.
REQ-011 Port: sin  in  1  serial fill bit; shl fills LSB, shr fills MSB; sampled at every step.
REQ-012 Port: out  out  WIDTH  register contents.
REQ-013 Port: sout  out  1  last bit shifted or rotated out (MSB for rol/shl, LSB for ror/shr/asr).
REQ-014 Port: busy  out  1  high while in SHIFT.
REQ-015 Port: done  out  1  one-cycle completion pulse.

Function
REQ-016 FSM states SHALL be IDLE and SHIFT only.
REQ-017 IDLE, start=1, e=1, op=load: out<=data at that edge; done=1 for the next cycle; busy stays 0; sout unchanged.
REQ-018 IDLE, start=1, e=1, shift/rotate op, amt>0: op and amt latched; counter<=amt; state<=SHIFT; out unchanged at that edge.
REQ-019 IDLE, start=1, e=1, amt=0 or op=nop: out unchanged; done=1 for the next cycle; no SHIFT entry.
REQ-020 SHIFT: each edge with e=1 performs exactly one one-bit step of the latched op, updates sout and decrements counter.
REQ-021 Step rules: rol/ror rotate; shl inserts sin at bit 0; shr inserts sin at bit WIDTH-1; asr replicates bit WIDTH-1.
REQ-022 Final step (counter=1): state<=IDLE; busy=0 and done=1 during the following cycle.
REQ-023 A shift of N steps with e held at 1 SHALL produce done exactly N+1 cycles after the acceptance edge.
REQ-024 amt greater than WIDTH SHALL execute all amt steps without clamping.
REQ-025 start, op, amt and data SHALL be ignored while busy=1.
REQ-026 e=0 in SHIFT SHALL freeze out, sout, counter and state; completion is delayed one cycle per frozen cycle.
REQ-027 done SHALL never be asserted for two consecutive cycles.

Reset
REQ-028 rst=1 at an edge SHALL set out=0, sout=0, busy=0, done=0, counter=0 and state=IDLE, regardless of e.
REQ-029 rst during SHIFT SHALL abort the operation with no done pulse.
REQ-030 rst SHALL take priority over a simultaneous start.

Structure
REQ-031 Package univ_shift_pkg SHALL hold the op encoding enum and the FSM state enum.
REQ-032 One combinational sub-module, shift_step, SHALL compute the next value and out-bit for one step; univ_shift_reg holds the FSM, counter and registers.

Verification (WIDTH=8)
REQ-033 Load: rst, then load 0xA5 -> out=0xA5 next cycle, done=1 for one cycle, busy=0 throughout.
REQ-034 Rotate: load 0x81, then rol amt=3 -> busy=1 for 3 cycles, out=0x0C, sout=0, done=1 on cycle 4.
REQ-035 Arithmetic and fill: load 0x80, then asr amt=3 -> out=0xF0. Load 0x01, then shr sin=1 amt=2 -> out=0xC0, sout=0.
REQ-036 Enable stall: rol amt=4 with e=0 for 2 cycles mid-operation -> out frozen while e=0; done at cycle 7; final value equals the unstalled run.
REQ-037 Reset abort: rst asserted in the second step of shl amt=5 -> next cycle out=0, busy=0; no done pulse follows.
REQ-038 Edge cases: start with amt=0 -> done next cycle, out unchanged. start during busy -> ignored; the original operation completes with its original op and amt.
